io_ccff_chain_loader: RTL and testbench
=======================================

// Module: io_ccff_chain_loader
// PURPOSE
//  Sequences the configuration-flip-flop (CCFF) chain of an IO tile column on prog_clk.
//  Accepts bitstream words over a valid/ready stream and serialises them LSB-first onto ccff_head.
//  Gates the chain with ccff_shift_en for exactly CHAIN_LEN shift cycles, then reports done.
//  Sits between the bitstream fetch logic and the first IO tile ccff_head of the chain.
// PARAMETERS
//  CHAIN_LEN  64    total CCFF bits in the chain (>=1)
//  WORD_W     8     cfg_data width; bits per accepted word (>=1)
//  TIMEOUT    1024  max cycles waiting in LOAD for cfg_valid before error (>=1)
// PORTS
//  prog_clk       in   1       configuration clock; all state on rising edge
//  prog_reset     in   1       synchronous, active-high reset
//  start          in   1       begin a chain load; sampled only in IDLE
//  cfg_data       in   WORD_W  bitstream word, bit 0 shifted first
//  cfg_valid      in   1       cfg_data valid
//  cfg_ready      out  1       loader accepts cfg_data this cycle
//  ccff_head      out  1       serial config bit into chain head
//  ccff_shift_en  out  1       chain shift enable; chain advances when 1
//  ccff_tail      in   1       serial bit from chain tail (used only with readback)
//  busy           out  1       1 in LOAD/SHIFT
//  done           out  1       one-cycle pulse after the last chain bit is shifted
//  err            out  1       sticky timeout flag; cleared by next accepted start or reset
//  rb_parity      out  1       XOR of all ccff_tail bits shifted out in last load
// BEHAVIOUR
//  Reset: state IDLE; cfg_ready, ccff_head, ccff_shift_en, busy, done, err, rb_parity = 0; counters 0.
//  IDLE: start=1 -> LOAD; bit_cnt<=0, err<=0, wait_cnt<=0. start while busy is ignored.
//  LOAD: cfg_ready=1. On cfg_valid&cfg_ready capture word, word_bits<=min(WORD_W, CHAIN_LEN-bit_cnt), -> SHIFT.
//    No handshake: wait_cnt++; wait_cnt==TIMEOUT-1 -> err<=1, -> IDLE (no done pulse).
//  SHIFT: registered ccff_head=shreg[0], ccff_shift_en=1 each cycle; shreg>>=1; bit_cnt++.
//    After word_bits shifts: bit_cnt==CHAIN_LEN -> DONE, else -> LOAD (wait_cnt<=0).
//    Excess bits of a final partial word are discarded, never shifted.
//  DONE: done=1 for one cycle, -> IDLE. ccff_shift_en=0 outside SHIFT; ccff_head holds last bit.
//  Throughput: one word per WORD_W+1 cycles (1 LOAD + WORD_W SHIFT), no overlap.
//  Latency: start->first shift = 2 cycles when cfg_valid already high.
//  bit_cnt width $clog2(CHAIN_LEN+1); wait_cnt width $clog2(TIMEOUT+1); no wrap possible.
//  Reset mid-load: immediate return to reset values; chain contents undefined, software reloads.
//  start and prog_reset same cycle: reset wins.
// CONFIGURATION
//  CCFF_READBACK_EN defined: on every SHIFT cycle rb_acc^=ccff_tail; rb_acc cleared on start;
//    rb_parity<=rb_acc on entry to DONE (parity of previous chain contents). Timeout leaves rb_parity unchanged.
//  Undefined: rb_parity tied 0, ccff_tail unused, no rb_acc register.
// STRUCTURE
//  Package io_ccff_pkg: state enum {IDLE, LOAD, SHIFT, DONE} (2-bit), clog2-based width constants.
//  Sub-module io_ccff_shift_reg: WORD_W parallel-load/serial-out register with load, shift, q0.
//  Top holds FSM, bit_cnt, wait_cnt, handshake, readback accumulator.
// TESTING
//  CHAIN_LEN=16,WORD_W=8: start, words 0xA5 then 0x3C back-to-back -> head 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; 16 shift_en; done at cycle 19.
//  CHAIN_LEN=12,WORD_W=8: words 0xFF,0x0F -> exactly 12 shift_en cycles, upper nibble of 0x0F never driven, done once.
//  TIMEOUT=4: start, cfg_valid held 0 -> err=1 after 4 LOAD cycles, state IDLE, no done, no shift_en.
//  prog_reset asserted mid-SHIFT of second word -> next cycle all outputs 0; new start reloads cleanly, err stays 0.
//  start pulsed during SHIFT -> ignored; bit count and done timing identical to uninterrupted load.
//  CCFF_READBACK_EN, CHAIN_LEN=8: model chain preloaded 0x07, load 0x00 -> rb_parity=1; reload 0x00 -> rb_parity=0.

Source files
------------

// File: rtl/io_ccff_pkg.sv
// Shared types and width helpers for the IO tile CCFF chain loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package io_ccff_pkg;

    // Default build-time sizes of the IO tile column chain
    localparam int CHAIN_LEN_DEF = 64;
    localparam int WORD_W_DEF    = 8;
    localparam int TIMEOUT_DEF   = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of a counter that must hold every value 0..max_val without wrapping
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/io_ccff_shift_reg.sv
// Parallel-load, serial-out word register feeding the chain head, LSB first.
// Latency: q0 reflects a load or shift on the following prog_clk edge.
// Backpressure: none; the owning FSM decides when to load or shift.
module io_ccff_shift_reg #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] d,
    output logic              q0
);

    logic [WORD_W-1:0] shreg;

    // Load has priority over shift; zeros fill from the top
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= d;
        end else if (shift) begin
            shreg <= shreg >> 1;
        end
    end

    assign q0 = shreg[0];

endmodule

// File: rtl/io_ccff_chain_loader.sv
// Serialises bitstream words LSB-first into an IO tile CCFF chain for exactly CHAIN_LEN shifts (CCFF_READBACK_EN adds tail parity).
// Latency: first shift 2 cycles after start with cfg_valid high; one word per WORD_W+1 cycles; done 1 cycle after last shift.
// Backpressure: cfg_ready only in LOAD; LOAD waits up to TIMEOUT cycles for cfg_valid, then raises sticky err and idles.
module io_ccff_chain_loader
    import io_ccff_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int WORD_W    = WORD_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rb_parity
);

    localparam int BW = cnt_w(CHAIN_LEN);
    localparam int TW = cnt_w(TIMEOUT);
    localparam int SW = cnt_w(WORD_W);

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   bit_cnt;
    logic [TW-1:0]   wait_cnt;
    logic [SW-1:0]   word_left;
    logic [SW-1:0]   word_bits;
    logic [BW-1:0]   bits_rem;
    logic            head_q;
    logic            err_q;
    logic            sr_q0;
    logic            cfg_hs;
    logic            last_shift;
    logic            chain_full;
    logic            load_timeout;

    assign cfg_hs       = (state == LOAD) && cfg_valid;
    assign last_shift   = (state == SHIFT) && (word_left == SW'(1));
    assign chain_full   = (bit_cnt == BW'(CHAIN_LEN - 1));
    assign load_timeout = (state == LOAD) && !cfg_valid && (wait_cnt == TW'(TIMEOUT - 1));
    // Bits of a final partial word beyond the chain end are never counted, so never shifted
    assign bits_rem     = BW'(CHAIN_LEN) - bit_cnt;
    assign word_bits    = (int'(bits_rem) >= WORD_W) ? SW'(WORD_W) : SW'(bits_rem);

    // State register; reset dominates a coincident start
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt     = state;
        cfg_ready     = 1'b0;
        ccff_shift_en = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (cfg_hs) begin
                    state_nxt = SHIFT;
                end else if (load_timeout) begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                ccff_shift_en = 1'b1;
                busy          = 1'b1;
                if (last_shift) state_nxt = chain_full ? DONE : LOAD;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, error flag and the registered chain head bit
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            word_left <= '0;
            head_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt  <= '0;
                        wait_cnt <= '0;
                        err_q    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        word_left <= word_bits;
                        head_q    <= cfg_data[0];
                    end else if (load_timeout) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                SHIFT: begin
                    bit_cnt   <= bit_cnt + BW'(1);
                    word_left <= word_left - SW'(1);
                    // Head holds the last bit of a word once it has been shifted
                    if (last_shift) begin
                        wait_cnt <= '0;
                    end else begin
                        head_q <= sr_q0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bit 0 goes straight to the head register, so the word register holds bits 1 and up
    io_ccff_shift_reg #(
        .WORD_W (WORD_W)
    ) u_shift_reg (
        .clk   (prog_clk),
        .rst   (prog_reset),
        .load  (cfg_hs),
        .shift (state == SHIFT),
        .d     (cfg_data >> 1),
        .q0    (sr_q0)
    );

    assign ccff_head = head_q;
    assign err       = err_q;

`ifdef CCFF_READBACK_EN
    logic rb_acc;
    logic rb_parity_q;

    // Parity of the old chain contents as they leave the tail; published when the load completes
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            rb_acc      <= 1'b0;
            rb_parity_q <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                rb_acc <= 1'b0;
            end else if (state == SHIFT) begin
                rb_acc <= rb_acc ^ ccff_tail;
            end
            if (last_shift && chain_full) begin
                rb_parity_q <= rb_acc ^ ccff_tail;
            end
        end
    end

    assign rb_parity = rb_parity_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign rb_parity   = 1'b0;
`endif

endmodule

// File: tb/tb_io_ccff_chain_loader.sv
// Self-checking bench for io_ccff_chain_loader with a behavioural chain model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
`timescale 1ns/1ps
module tb_io_ccff_chain_loader;

    localparam int CL = 12;
    localparam int WW = 8;
    localparam int TO = 4;
    localparam int NW = (CL + WW - 1) / WW;

    logic          prog_clk;
    logic          prog_reset = 1'b1;
    logic          start      = 1'b0;
    logic [WW-1:0] cfg_data   = '0;
    logic          cfg_valid  = 1'b0;
    logic          cfg_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          err;
    logic          rb_parity;

    int   total  = 0;
    int   bad    = 0;
    logic exp_rb = 1'b0;

    // Behavioural model of the physical chain: shifts in the head bit whenever enabled
    logic [CL-1:0] chain = '0;

    io_ccff_chain_loader #(
        .CHAIN_LEN (CL),
        .WORD_W    (WW),
        .TIMEOUT   (TO)
    ) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .rb_parity     (rb_parity)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
    end
    assign ccff_tail = chain[CL-1];

    // Readback parity equals parity of whatever the chain held before the load
    function automatic logic exp_parity(input logic [CL-1:0] c);
`ifdef CCFF_READBACK_EN
        return ^c;
`else
        return 1'b0 & c[0];
`endif
    endfunction

    task automatic test_reset();
        prog_reset = 1'b1;
        start      = 1'b0;
        cfg_valid  = 1'b0;
        repeat (3) @(negedge prog_clk);
        total++;
        if ({cfg_ready, ccff_head, ccff_shift_en, busy, done, err, rb_parity} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0000000",
                     {cfg_ready, ccff_head, ccff_shift_en, busy, done, err, rb_parity});
        end
        prog_reset = 1'b0;
        repeat (2) @(negedge prog_clk);
        total++;
        if ({cfg_ready, ccff_shift_en, busy, done, err} !== 5'b0) begin
            bad++;
            $display("FAIL idle_after_reset got=%b want=00000", {cfg_ready, ccff_shift_en, busy, done, err});
        end
        exp_rb = 1'b0;
    endtask

    // One full chain load; words fixed or random, optional LOAD gaps and a stray start pulse
    task automatic run_load(input string name, input logic fixed, input logic [WW-1:0] w0,
                            input logic [WW-1:0] w1, input int max_gap, input int poke_cyc);
        logic [WW-1:0] words[$];
        int            gaps[$];
        logic          bits[$];
        logic          rb_new;
        int            nshift   = 0;
        int            ndone    = 0;
        int            done_cyc = -1;
        int            widx     = 0;
        int            gap_left;
        int            exp_done;
        for (int i = 0; i < NW; i++) begin
            if (fixed) words.push_back((i == 0) ? w0 : w1);
            else       words.push_back(WW'($urandom));
            gaps.push_back((max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
        if (max_gap > 0) gaps[NW-1] = max_gap;
        for (int i = 0; i < CL; i++) bits.push_back(words[i / WW][i % WW]);
        exp_done = 1;
        for (int i = 0; i < NW; i++) begin
            exp_done += gaps[i] + 1 + (((CL - i * WW) < WW) ? (CL - i * WW) : WW);
        end
        rb_new    = exp_parity(chain);
        gap_left  = gaps[0];
        start     = 1'b1;
        cfg_valid = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge prog_clk);
            if (cyc == 1) begin
                total++;
                if ({busy, err} !== 2'b10) begin
                    bad++;
                    $display("FAIL %s busy_err_after_start got=%b want=10", name, {busy, err});
                end
            end
            if (ccff_shift_en) begin
                total++;
                if (nshift >= CL) begin
                    bad++;
                    $display("FAIL %s extra_shift count=%0d want_max=%0d", name, nshift + 1, CL);
                end else if (ccff_head !== bits[nshift]) begin
                    bad++;
                    $display("FAIL %s head_bit%0d got=%b want=%b", name, nshift, ccff_head, bits[nshift]);
                end
                nshift++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    total++;
                    if (ccff_head !== bits[CL-1]) begin
                        bad++;
                        $display("FAIL %s head_hold got=%b want=%b", name, ccff_head, bits[CL-1]);
                    end
                    total++;
                    if (rb_parity !== rb_new) begin
                        bad++;
                        $display("FAIL %s rb_parity got=%b want=%b", name, rb_parity, rb_new);
                    end
                end
            end
            if ((done_cyc > 0) && (cyc == done_cyc + 1)) begin
                total++;
                if ({cfg_ready, ccff_shift_en, busy, done, err} !== 5'b0) begin
                    bad++;
                    $display("FAIL %s idle_after_done got=%b want=00000", name,
                             {cfg_ready, ccff_shift_en, busy, done, err});
                end
                break;
            end
            start = (cyc == poke_cyc);
            if (cfg_ready) begin
                if (gap_left > 0) begin
                    cfg_valid = 1'b0;
                    cfg_data  = WW'($urandom);
                    gap_left--;
                end else if (widx < NW) begin
                    cfg_valid = 1'b1;
                    cfg_data  = words[widx];
                    widx++;
                    if (widx < NW) gap_left = gaps[widx];
                end else begin
                    cfg_valid = 1'b0;
                end
            end else begin
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_data  = WW'($urandom);
            end
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL %s done_count got=%0d want=1", name, ndone);
        end
        total++;
        if (nshift != CL) begin
            bad++;
            $display("FAIL %s shift_count got=%0d want=%0d", name, nshift, CL);
        end
        total++;
        if (done_cyc != exp_done) begin
            bad++;
            $display("FAIL %s done_cycle got=%0d want=%0d", name, done_cyc, exp_done);
        end
        exp_rb    = rb_new;
        start     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic test_pattern();
        run_load("pattern_a5_3c", 1'b1, 8'hA5, 8'h3C, 0, -1);
    endtask

    task automatic test_partial_word();
        run_load("partial_ff_0f", 1'b1, 8'hFF, 8'h0F, 0, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            run_load("random", 1'b0, '0, '0, (n % 2 == 1) ? TO - 1 : 0, -1);
        end
    endtask

    task automatic test_start_ignored();
        run_load("start_in_shift", 1'b1, 8'h5A, 8'hC3, 0, 5);
        run_load("start_in_load", 1'b1, 8'h96, 8'h69, 0, 10);
    endtask

    // Starve LOAD of cfg_valid after a number of accepted words
    task automatic test_timeout(input int words_before);
        int nready    = 0;
        int nshift    = 0;
        int ndone     = 0;
        int first_err = -1;
        int widx      = 0;
        int err_cyc   = 1 + words_before * (1 + WW) + TO;
        start     = 1'b1;
        cfg_valid = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge prog_clk);
            if (cfg_ready) nready++;
            if (ccff_shift_en) nshift++;
            if (done) ndone++;
            if (err && (first_err < 0)) first_err = cyc;
            if (cyc == err_cyc + 5) break;
            start = 1'b0;
            if (cfg_ready && (widx < words_before)) begin
                cfg_valid = 1'b1;
                cfg_data  = WW'($urandom);
                widx++;
            end else begin
                cfg_valid = 1'b0;
            end
        end
        total++;
        if (first_err != err_cyc) begin
            bad++;
            $display("FAIL timeout%0d err_cycle got=%0d want=%0d", words_before, first_err, err_cyc);
        end
        total++;
        if (nready != words_before + TO) begin
            bad++;
            $display("FAIL timeout%0d load_cycles got=%0d want=%0d", words_before, nready, words_before + TO);
        end
        total++;
        if ((nshift != words_before * WW) || (ndone != 0)) begin
            bad++;
            $display("FAIL timeout%0d shifts_done got=%0d/%0d want=%0d/0", words_before, nshift, ndone,
                     words_before * WW);
        end
        total++;
        if ({err, busy, rb_parity} !== {2'b10, exp_rb}) begin
            bad++;
            $display("FAIL timeout%0d sticky got=%b want=%b", words_before, {err, busy, rb_parity},
                     {2'b10, exp_rb});
        end
    endtask

    // Reset while the second word is shifting, with a coincident start that must lose
    task automatic test_reset_mid();
        start     = 1'b1;
        cfg_valid = 1'b0;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            @(negedge prog_clk);
            if (cyc == 12) begin
                total++;
                if (ccff_shift_en !== 1'b1) begin
                    bad++;
                    $display("FAIL reset_mid in_shift got=%b want=1", ccff_shift_en);
                end
                prog_reset = 1'b1;
                start      = 1'b1;
            end else if (cyc == 13) begin
                total++;
                if ({cfg_ready, ccff_head, ccff_shift_en, busy, done, err, rb_parity} !== 7'b0) begin
                    bad++;
                    $display("FAIL reset_mid outputs got=%b want=0000000",
                             {cfg_ready, ccff_head, ccff_shift_en, busy, done, err, rb_parity});
                end
                prog_reset = 1'b0;
                start      = 1'b0;
                cfg_valid  = 1'b0;
            end else begin
                start     = 1'b0;
                cfg_valid = cfg_ready;
                cfg_data  = WW'($urandom);
            end
        end
        @(negedge prog_clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_wins_over_start busy got=%b want=0", busy);
        end
        exp_rb = 1'b0;
        run_load("reload_after_reset", 1'b0, '0, '0, 0, -1);
    endtask

    task automatic test_readback();
        run_load("rb_preload_07", 1'b1, 8'h07, 8'h00, 0, -1);
        run_load("rb_load_00_a", 1'b1, 8'h00, 8'h00, 0, -1);
        run_load("rb_load_00_b", 1'b1, 8'h00, 8'h00, 0, -1);
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_partial_word();
        test_random();
        test_start_ignored();
        test_timeout(0);
        run_load("load_after_timeout", 1'b0, '0, '0, 0, -1);
        test_timeout(1);
        test_reset_mid();
        test_readback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
